// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the byte-wide unified memory port between icache
// refills and LSB loads/stores. It splits each request into byte beats,
// reassembles read data little-endian and returns a one-cycle done pulse.
module mem_ctrl #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  need_flush_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  icache_miss_in,
    input  logic [31:0]           icache_addr_in,
    output logic                  icache_valid_out,
    output logic [31:0]           icache_instr_out,
    output logic                  busy_out,
    input  logic                  lsb_valid_in,
    input  logic                  lsb_wr_in,
    input  logic [1:0]            lsb_size_in,
    input  logic [31:0]           lsb_addr_in,
    input  logic [31:0]           lsb_data_in,
    output logic                  lsb_ready_out,
    output logic [31:0]           lsb_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        LOAD   = 2'd2,
        STORE  = 2'd3
    } state_t;

    // Index of the final byte beat for an access size; size 3 behaves as a word.
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        case (size)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;     // byte currently driven / pending
    logic [1:0]              last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             data_q, data_d;   // store data or read assembly buffer
    logic [ADDR_WIDTH-1:0]   mem_a_q, mem_a_d;
    logic [7:0]              mem_dout_q, mem_dout_d;
    logic                    mem_wr_q, mem_wr_d;
    logic                    ic_valid_q, ic_valid_d;
    logic [31:0]             ic_instr_q, ic_instr_d;
    logic                    lsb_ready_q, lsb_ready_d;
    logic [31:0]             lsb_data_q, lsb_data_d;

    logic [31:0]             merged;
    logic [1:0]              pend;
    logic                    io_stall;

    // Next-state and next-output logic for the beat sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        ic_valid_d  = 1'b0;
        ic_instr_d  = 32'h0;
        lsb_ready_d = 1'b0;
        lsb_data_d  = 32'h0;

        merged = data_q;
        merged[{cnt_q, 3'b000} +: 8] = mem_din;
        // A store byte is only consumed when it was driven with mem_wr high;
        // after a stall cycle the same byte is still pending.
        pend     = mem_wr_q ? cnt_q + 2'd1 : cnt_q;
        io_stall = (addr_q[17:16] == IO_BASE_HI) && io_buffer_full;

        case (state_q)
            IDLE: begin
                if (!need_flush_in) begin
                    if (lsb_valid_in && !lsb_ready_q) begin
                        addr_d  = ADDR_WIDTH'(lsb_addr_in);
                        cnt_d   = 2'd0;
                        last_d  = last_beat(lsb_size_in);
                        mem_a_d = ADDR_WIDTH'(lsb_addr_in);
                        if (lsb_wr_in) begin
                            state_d    = STORE;
                            data_d     = lsb_data_in;
                            mem_dout_d = lsb_data_in[7:0];
                            mem_wr_d   = !((lsb_addr_in[17:16] == IO_BASE_HI) && io_buffer_full);
                        end else begin
                            state_d    = LOAD;
                            data_d     = 32'h0;
                            mem_dout_d = 8'h0;
                            mem_wr_d   = 1'b0;
                        end
                    end else if (icache_miss_in && !ic_valid_q) begin
                        state_d    = IFETCH;
                        addr_d     = ADDR_WIDTH'(icache_addr_in);
                        cnt_d      = 2'd0;
                        last_d     = 2'd3;
                        data_d     = 32'h0;
                        mem_a_d    = ADDR_WIDTH'(icache_addr_in);
                        mem_dout_d = 8'h0;
                        mem_wr_d   = 1'b0;
                    end
                end
            end
            IFETCH, LOAD: begin
                if (need_flush_in) begin
                    state_d  = IDLE;
                    mem_a_d  = '0;
                    mem_wr_d = 1'b0;
                end else begin
                    data_d = merged;
                    if (cnt_q == last_q) begin
                        state_d = IDLE;
                        mem_a_d = '0;
                        if (state_q == IFETCH) begin
                            ic_valid_d = 1'b1;
                            ic_instr_d = merged;
                        end else begin
                            lsb_ready_d = 1'b1;
                            lsb_data_d  = merged;
                        end
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        mem_a_d = addr_q + ADDR_WIDTH'(cnt_q + 2'd1);
                    end
                end
            end
            STORE: begin
                // Stores are committed, so a flush never interrupts them.
                if (mem_wr_q && (cnt_q == last_q)) begin
                    state_d     = IDLE;
                    mem_a_d     = '0;
                    mem_dout_d  = 8'h0;
                    mem_wr_d    = 1'b0;
                    lsb_ready_d = 1'b1;
                end else begin
                    cnt_d      = pend;
                    mem_a_d    = addr_q + ADDR_WIDTH'(pend);
                    mem_dout_d = data_q[{pend, 3'b000} +: 8];
                    mem_wr_d   = !io_stall;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; rdy_in low freezes everything including pulses.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            last_q      <= 2'd0;
            addr_q      <= '0;
            data_q      <= 32'h0;
            mem_a_q     <= '0;
            mem_dout_q  <= 8'h0;
            mem_wr_q    <= 1'b0;
            ic_valid_q  <= 1'b0;
            ic_instr_q  <= 32'h0;
            lsb_ready_q <= 1'b0;
            lsb_data_q  <= 32'h0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            ic_valid_q  <= ic_valid_d;
            ic_instr_q  <= ic_instr_d;
            lsb_ready_q <= lsb_ready_d;
            lsb_data_q  <= lsb_data_d;
        end
    end

    assign mem_a            = mem_a_q;
    assign mem_dout         = mem_dout_q;
    assign mem_wr           = mem_wr_q;
    assign icache_valid_out = ic_valid_q;
    assign icache_instr_out = ic_instr_q;
    assign lsb_ready_out    = lsb_ready_q;
    assign lsb_data_out     = lsb_data_q;
    // Busy through the refill pulse so the icache cannot re-request while writing the line.
    assign busy_out         = (state_q != IDLE) || ic_valid_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected done pulses
// (kind, data, cycle); a negedge monitor pops and compares them.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, need_flush_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;
    logic        icache_miss_in, icache_valid_out, busy_out;
    logic [31:0] icache_addr_in, icache_instr_out;
    logic        lsb_valid_in, lsb_wr_in, lsb_ready_out;
    logic [1:0]  lsb_size_in;
    logic [31:0] lsb_addr_in, lsb_data_in, lsb_data_out;

    typedef struct {
        bit          is_ic;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t        sb[$];
    wr_t         wlog[$];
    logic [7:0]  ram [0:65535];
    logic [7:0]  exp_b [4];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          acc;
    logic        ic_prev = 1'b0;
    logic        lsb_prev = 1'b0;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.ADDR_WIDTH(32), .IO_BASE_HI(2'b11)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .need_flush_in    (need_flush_in),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .io_buffer_full   (io_buffer_full),
        .icache_miss_in   (icache_miss_in),
        .icache_addr_in   (icache_addr_in),
        .icache_valid_out (icache_valid_out),
        .icache_instr_out (icache_instr_out),
        .busy_out         (busy_out),
        .lsb_valid_in     (lsb_valid_in),
        .lsb_wr_in        (lsb_wr_in),
        .lsb_size_in      (lsb_size_in),
        .lsb_addr_in      (lsb_addr_in),
        .lsb_data_in      (lsb_data_in),
        .lsb_ready_out    (lsb_ready_out),
        .lsb_data_out     (lsb_data_out)
    );

    // RAM: the byte for the address driven in a cycle is sampled at the next edge.
    assign mem_din = ram[mem_a[15:0]];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(posedge clk_in) begin
        if (!rst_in && rdy_in && mem_wr) wlog.push_back('{a: mem_a, d: mem_dout});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input bit is_ic, input logic [31:0] data, input int at);
        sb.push_back('{is_ic: is_ic, data: data, cyc: at});
    endtask

    task automatic sb_pop(input bit is_ic, input logic [31:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse icache=%0d data=%0h expected=no pulse (cycle %0d)", is_ic, data, cyc);
        end else begin
            e = sb.pop_front();
            check("pulse_kind", 64'(is_ic), 64'(e.is_ic));
            check("pulse_data", 64'(data), 64'(e.data));
            check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        end
    endtask

    // Monitor: compares each new done pulse against the scoreboard head.
    always @(negedge clk_in) begin
        if (icache_valid_out && !ic_prev) sb_pop(1'b1, icache_instr_out);
        if (lsb_ready_out && !lsb_prev) sb_pop(1'b0, lsb_data_out);
        if (!icache_valid_out) check("ic_data_zero", 64'(icache_instr_out), 64'h0);
        if (!lsb_ready_out) check("lsb_data_zero", 64'(lsb_data_out), 64'h0);
        ic_prev  <= icache_valid_out;
        lsb_prev <= lsb_ready_out;
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    // Full refill starting at a negedge; ends one cycle after the pulse.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] word);
        int start;
        icache_addr_in = a;
        icache_miss_in = 1'b1;
        start = cyc + 1;
        sb_push(1'b1, word, start + 4);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fetch_addr", 64'(mem_a), 64'(a + 32'(k)));
            check("fetch_busy", 64'(busy_out), 64'h1);
        end
        tick();
        check("fetch_busy_pulse", 64'(busy_out), 64'h1);
        check("fetch_addr_idle", 64'(mem_a), 64'h0);
        icache_miss_in = 1'b0;
        tick();
        check("fetch_busy_after", 64'(busy_out), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
        ram[16'h2002] = 8'hAB; ram[16'h2003] = 8'hCD;
        ram[16'h5000] = 8'h01; ram[16'h5001] = 8'h02; ram[16'h5002] = 8'h03; ram[16'h5003] = 8'h04;

        rst_in = 1'b1; rdy_in = 1'b1; need_flush_in = 1'b0; io_buffer_full = 1'b0;
        icache_miss_in = 1'b0; icache_addr_in = 32'h0;
        lsb_valid_in = 1'b0; lsb_wr_in = 1'b0; lsb_size_in = 2'd0;
        lsb_addr_in = 32'h0; lsb_data_in = 32'h0;
        #23 rst_in = 1'b0;
        tick();

        // Reset state
        check("rst_mem_a", 64'(mem_a), 64'h0);
        check("rst_mem_wr", 64'(mem_wr), 64'h0);
        check("rst_mem_dout", 64'(mem_dout), 64'h0);
        check("rst_busy", 64'(busy_out), 64'h0);
        check("rst_ic_valid", 64'(icache_valid_out), 64'h0);
        check("rst_lsb_ready", 64'(lsb_ready_out), 64'h0);

        // Plain refill at 0x1000 -> 0x00000513
        do_fetch(32'h1000, 32'h00000513);

        // Load (size 1 at 0x2002) beats a simultaneous refill; refill follows next edge
        lsb_valid_in = 1'b1; lsb_wr_in = 1'b0; lsb_size_in = 2'd1; lsb_addr_in = 32'h2002;
        icache_miss_in = 1'b1; icache_addr_in = 32'h1000;
        acc = cyc + 1;
        sb_push(1'b0, 32'h0000CDAB, acc + 2);
        tick();
        check("arb_load_first", 64'(mem_a), 64'h2002);
        tick();
        check("arb_load_beat1", 64'(mem_a), 64'h2003);
        tick();
        lsb_valid_in = 1'b0;
        sb_push(1'b1, 32'h00000513, acc + 7);
        tick();
        check("arb_fetch_next", 64'(mem_a), 64'h1000);
        repeat (3) tick();
        tick();
        icache_miss_in = 1'b0;
        tick();

        // Asynchronous reset mid-refill, then a normal refill
        icache_addr_in = 32'h1000; icache_miss_in = 1'b1;
        tick();
        tick();
        #1 rst_in = 1'b1;
        #1;
        check("arst_mem_a", 64'(mem_a), 64'h0);
        check("arst_busy", 64'(busy_out), 64'h0);
        check("arst_mem_wr", 64'(mem_wr), 64'h0);
        icache_miss_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        do_fetch(32'h1000, 32'h00000513);

        // IO store with the write buffer full for 3 cycles at byte 1
        wlog.delete();
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        lsb_valid_in = 1'b1; lsb_wr_in = 1'b1; lsb_size_in = 2'd2;
        lsb_addr_in = 32'h0003_0000; lsb_data_in = 32'hDEADBEEF;
        acc = cyc + 1;
        sb_push(1'b0, 32'h0, acc + 7);
        tick();
        check("io_st_b0_wr", 64'(mem_wr), 64'h1);
        check("io_st_b0_dout", 64'(mem_dout), 64'hEF);
        io_buffer_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("io_st_stall_wr", 64'(mem_wr), 64'h0);
        end
        io_buffer_full = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            check("io_st_wr", 64'(mem_wr), 64'h1);
            check("io_st_addr", 64'(mem_a), 64'(32'h0003_0000 + 32'(k)));
            check("io_st_dout", 64'(mem_dout), 64'(exp_b[k]));
        end
        tick();
        lsb_valid_in = 1'b0;
        check("io_st_wr_done", 64'(mem_wr), 64'h0);
        check("io_st_count", 64'(wlog.size()), 64'd4);
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            check("io_st_log_addr", 64'(wlog[k].a), 64'(32'h0003_0000 + 32'(k)));
            check("io_st_log_data", 64'(wlog[k].d), 64'(exp_b[k]));
        end
        tick();

        // Flush during refill at cnt=2: abort, no pulse
        icache_addr_in = 32'h1000; icache_miss_in = 1'b1;
        tick();
        tick();
        tick();
        check("flush_if_cnt2_addr", 64'(mem_a), 64'h1002);
        need_flush_in = 1'b1; icache_miss_in = 1'b0;
        tick();
        need_flush_in = 1'b0;
        check("flush_if_mem_a", 64'(mem_a), 64'h0);
        check("flush_if_busy", 64'(busy_out), 64'h0);
        check("flush_if_wr", 64'(mem_wr), 64'h0);
        repeat (3) tick();

        // Flush during a store: the store still completes
        wlog.delete();
        exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
        lsb_valid_in = 1'b1; lsb_wr_in = 1'b1; lsb_size_in = 2'd2;
        lsb_addr_in = 32'h0000_4000; lsb_data_in = 32'h11223344;
        acc = cyc + 1;
        sb_push(1'b0, 32'h0, acc + 4);
        tick();
        need_flush_in = 1'b1;
        tick();
        need_flush_in = 1'b0;
        check("flush_st_continue_wr", 64'(mem_wr), 64'h1);
        check("flush_st_continue_a", 64'(mem_a), 64'h4001);
        repeat (2) tick();
        tick();
        lsb_valid_in = 1'b0;
        check("flush_st_count", 64'(wlog.size()), 64'd4);
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            check("flush_st_log_addr", 64'(wlog[k].a), 64'(32'h0000_4000 + 32'(k)));
            check("flush_st_log_data", 64'(wlog[k].d), 64'(exp_b[k]));
        end
        tick();

        // rdy_in low for 5 cycles mid-load: pulse shifts by exactly 5
        lsb_valid_in = 1'b1; lsb_wr_in = 1'b0; lsb_size_in = 2'd2; lsb_addr_in = 32'h5000;
        acc = cyc + 1;
        sb_push(1'b0, 32'h04030201, acc + 9);
        tick();
        check("rdy_ld_a0", 64'(mem_a), 64'h5000);
        tick();
        check("rdy_ld_a1", 64'(mem_a), 64'h5001);
        rdy_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rdy_frozen_a", 64'(mem_a), 64'h5001);
            check("rdy_frozen_busy", 64'(busy_out), 64'h1);
        end
        rdy_in = 1'b1;
        tick();
        check("rdy_resume_a2", 64'(mem_a), 64'h5002);
        tick();
        check("rdy_resume_a3", 64'(mem_a), 64'h5003);
        tick();
        // Keep the request up through the pulse cycle: it must be ignored.
        tick();
        check("ignore_while_pulse_a", 64'(mem_a), 64'h0);
        check("ignore_while_pulse_busy", 64'(busy_out), 64'h0);
        lsb_valid_in = 1'b0;
        tick();

        // Size 3 behaves as a word load
        lsb_valid_in = 1'b1; lsb_wr_in = 1'b0; lsb_size_in = 2'd3; lsb_addr_in = 32'h5000;
        acc = cyc + 1;
        sb_push(1'b0, 32'h04030201, acc + 4);
        repeat (4) tick();
        check("size3_last_addr", 64'(mem_a), 64'h5003);
        tick();
        lsb_valid_in = 1'b0;
        repeat (3) tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
